// File: rtl/seven_seg_capture.sv
// Captures a multiplexed four-digit seven-segment display back into a 16-bit hex word.
// Inputs are synchronized, debounced by a stability counter, decoded, and assembled into frames.
module seven_seg_capture #(
   parameter int CLK_FREQ      = 100_000_000,
   parameter int SETTLE_CYCLES = 16
) (
   input  logic        clk_i,
   input  logic        reset_ni,
   input  logic [6:0]  segs_i,
   input  logic [3:0]  anodes_i,
   input  logic        clear_i,
   output logic [15:0] data_o,
   output logic        valid_o,
   output logic        frame_o,
   output logic [1:0]  err_o
);

   localparam int             CW         = 16;
   localparam logic [CW-1:0]  SETTLE_MAX = CW'(SETTLE_CYCLES);
   localparam logic [CW-1:0]  SETTLE_M1  = CW'(SETTLE_CYCLES - 1);
   localparam logic [10:0]    SAMPLE_IDLE = 11'h7FF;

   // Returns {hit, nibble}; hit is 0 for any pattern outside the hex table.
   function automatic logic [4:0] decode_seg(input logic [6:0] seg);
      logic [4:0] res;
      case (seg)
         7'b1000000: res = 5'b1_0000;
         7'b1111001: res = 5'b1_0001;
         7'b0100100: res = 5'b1_0010;
         7'b0110000: res = 5'b1_0011;
         7'b0011001: res = 5'b1_0100;
         7'b0010010: res = 5'b1_0101;
         7'b0000010: res = 5'b1_0110;
         7'b1111000: res = 5'b1_0111;
         7'b0000000: res = 5'b1_1000;
         7'b0010000: res = 5'b1_1001;
         7'b0001000: res = 5'b1_1010;
         7'b0000011: res = 5'b1_1011;
         7'b1000110: res = 5'b1_1100;
         7'b0100001: res = 5'b1_1101;
         7'b0000110: res = 5'b1_1110;
         7'b0001110: res = 5'b1_1111;
         default:    res = 5'b0_0000;
      endcase
      return res;
   endfunction

   // Returns {single, index}; single is 1 only when exactly one anode is driven low.
   function automatic logic [2:0] anode_sel(input logic [3:0] an);
      logic [2:0] res;
      case (an)
         4'b1110: res = 3'b1_00;
         4'b1101: res = 3'b1_01;
         4'b1011: res = 3'b1_10;
         4'b0111: res = 3'b1_11;
         default: res = 3'b0_00;
      endcase
      return res;
   endfunction

   logic [10:0]   sync1_q, sync1_d;
   logic [10:0]   sync2_q, sync2_d;
   logic [10:0]   prev_q,  prev_d;
   logic [CW-1:0] cnt_q,   cnt_d;
   logic [15:0]   data_q,  data_d;
   logic [3:0]    mask_q,  mask_d;
   logic          valid_q, valid_d;
   logic          frame_q, frame_d;
   logic [1:0]    err_q,   err_d;

   logic          accept_s;
   logic [6:0]    seg_s;
   logic [3:0]    an_s;
   logic [4:0]    dec_s;
   logic [2:0]    sel_s;
   logic [3:0]    mask_next_s;

   assign seg_s = sync2_q[10:4];
   assign an_s  = sync2_q[3:0];
   assign dec_s = decode_seg(seg_s);
   assign sel_s = anode_sel(an_s);

   // Next-state logic: synchronizer, stability counter, decode and frame assembly.
   always_comb begin
      sync1_d     = {segs_i, anodes_i};
      sync2_d     = sync1_q;
      prev_d      = sync2_q;
      cnt_d       = cnt_q;
      data_d      = data_q;
      mask_d      = mask_q;
      valid_d     = valid_q;
      frame_d     = 1'b0;
      err_d       = err_q;
      mask_next_s = mask_q | (4'b0001 << sel_s[1:0]);

      // Accept fires exactly once, on the step from SETTLE_CYCLES-1 to SETTLE_CYCLES.
      accept_s = (sync2_q == prev_q) && (cnt_q == SETTLE_M1);

      if (clear_i) begin
         cnt_d = {CW{1'b0}};
      end else if (sync2_q != prev_q) begin
         cnt_d = {CW{1'b0}};
      end else if (cnt_q < SETTLE_MAX) begin
         cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
      end else begin
         cnt_d = cnt_q;
      end

      if (clear_i) begin
         data_d  = 16'h0000;
         mask_d  = 4'b0000;
         valid_d = 1'b0;
         err_d   = 2'b00;
      end else if (accept_s) begin
         if (an_s == 4'b1111) begin
            data_d = data_q;
         end else if (!sel_s[2]) begin
            err_d[1] = 1'b1;
         end else if (!dec_s[4]) begin
            err_d[0] = 1'b1;
         end else begin
            data_d[{sel_s[1:0], 2'b00} +: 4] = dec_s[3:0];
            if (mask_next_s == 4'b1111) begin
               frame_d = 1'b1;
               valid_d = 1'b1;
               mask_d  = 4'b0000;
            end else begin
               mask_d  = mask_next_s;
            end
         end
      end else begin
         data_d = data_q;
      end
   end

   // State registers; reset parks the synchronizers at the blank/inactive pattern.
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         sync1_q <= SAMPLE_IDLE;
         sync2_q <= SAMPLE_IDLE;
         prev_q  <= SAMPLE_IDLE;
         cnt_q   <= {CW{1'b0}};
         data_q  <= 16'h0000;
         mask_q  <= 4'b0000;
         valid_q <= 1'b0;
         frame_q <= 1'b0;
         err_q   <= 2'b00;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         prev_q  <= prev_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
         mask_q  <= mask_d;
         valid_q <= valid_d;
         frame_q <= frame_d;
         err_q   <= err_d;
      end
   end

   assign data_o  = data_q;
   assign valid_o = valid_q;
   assign frame_o = frame_q;
   assign err_o   = err_q;

endmodule

// File: tb/tb_seven_seg_capture.sv
// Directed self-checking bench for seven_seg_capture with SETTLE_CYCLES = 4.
module tb_seven_seg_capture;

   localparam logic [6:0] SEG_1 = 7'b1111001;
   localparam logic [6:0] SEG_2 = 7'b0100100;
   localparam logic [6:0] SEG_3 = 7'b0110000;
   localparam logic [6:0] SEG_4 = 7'b0011001;
   localparam logic [6:0] SEG_A = 7'b0001000;
   localparam logic [6:0] SEG_OFF = 7'b1111111;
   localparam logic [3:0] AN_0 = 4'b1110;
   localparam logic [3:0] AN_1 = 4'b1101;
   localparam logic [3:0] AN_2 = 4'b1011;
   localparam logic [3:0] AN_3 = 4'b0111;
   localparam logic [3:0] AN_NONE = 4'b1111;

   logic        clk_i = 1'b0;
   logic        reset_ni;
   logic [6:0]  segs_i;
   logic [3:0]  anodes_i;
   logic        clear_i;
   logic [15:0] data_o;
   logic        valid_o;
   logic        frame_o;
   logic [1:0]  err_o;

   int checks = 0;
   int failures = 0;
   int frame_cnt = 0;
   int frame_base;

   seven_seg_capture #(
      .CLK_FREQ(100_000_000),
      .SETTLE_CYCLES(4)
   ) dut (
      .clk_i(clk_i),
      .reset_ni(reset_ni),
      .segs_i(segs_i),
      .anodes_i(anodes_i),
      .clear_i(clear_i),
      .data_o(data_o),
      .valid_o(valid_o),
      .frame_o(frame_o),
      .err_o(err_o)
   );

   always #5 clk_i = ~clk_i;

   always @(posedge clk_i) begin
      if (frame_o) frame_cnt <= frame_cnt + 1;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Drive a pattern and hold it for n clocks; returns 1ns after the last edge.
   task automatic hold(input logic [3:0] an, input logic [6:0] sg, input int n);
      anodes_i = an;
      segs_i   = sg;
      repeat (n) @(posedge clk_i);
      #1;
   endtask

   initial begin
      reset_ni = 1'b0;
      clear_i  = 1'b0;
      anodes_i = AN_NONE;
      segs_i   = SEG_OFF;
      repeat (3) @(posedge clk_i);
      #1;
      check_eq("rst_data",  32'(data_o),  32'h0000);
      check_eq("rst_valid", 32'(valid_o), 32'h0);
      check_eq("rst_frame", 32'(frame_o), 32'h0);
      check_eq("rst_err",   32'(err_o),   32'h0);
      reset_ni = 1'b1;
      hold(AN_NONE, SEG_OFF, 10);
      check_eq("blank_data", 32'(data_o), 32'h0000);

      // Full frame 1234
      frame_base = frame_cnt;
      hold(AN_0, SEG_4, 10);
      hold(AN_1, SEG_3, 10);
      hold(AN_2, SEG_2, 10);
      check_eq("partial_valid", 32'(valid_o), 32'h0);
      hold(AN_3, SEG_1, 10);
      hold(AN_NONE, SEG_OFF, 10);
      check_eq("frame_data",  32'(data_o), 32'h1234);
      check_eq("frame_count", 32'(frame_cnt - frame_base), 32'd1);
      check_eq("frame_valid", 32'(valid_o), 32'h1);
      check_eq("frame_err",   32'(err_o),   32'h0);

      // Latency: update after E0+6, not after E0+5
      anodes_i = AN_0;
      segs_i   = SEG_A;
      repeat (6) @(posedge clk_i);
      #1;
      check_eq("lat_before", 32'(data_o[3:0]), 32'h4);
      @(posedge clk_i);
      #1;
      check_eq("lat_after", 32'(data_o[3:0]), 32'hA);

      // Short glitch must not update
      hold(AN_0, SEG_A, 6);
      hold(AN_0, SEG_1, 3);
      hold(AN_0, SEG_A, 10);
      check_eq("glitch_data", 32'(data_o), 32'h123A);
      check_eq("glitch_err",  32'(err_o),  32'h0);

      // Multi-anode error, then bad pattern error
      hold(4'b1100, SEG_A, 10);
      check_eq("multi_err", 32'(err_o), 32'h2);
      hold(AN_0, SEG_OFF, 10);
      check_eq("both_err",  32'(err_o),  32'h3);
      check_eq("err_data",  32'(data_o), 32'h123A);

      // Plain clear
      hold(AN_NONE, SEG_OFF, 10);
      clear_i = 1'b1;
      @(posedge clk_i);
      #1;
      clear_i = 1'b0;
      check_eq("clr_data",  32'(data_o),  32'h0000);
      check_eq("clr_valid", 32'(valid_o), 32'h0);
      check_eq("clr_err",   32'(err_o),   32'h0);

      // Reset mid-frame
      frame_base = frame_cnt;
      hold(AN_0, SEG_4, 10);
      hold(AN_1, SEG_3, 10);
      check_eq("pre_rst_data", 32'(data_o), 32'h0034);
      anodes_i = AN_NONE;
      segs_i   = SEG_OFF;
      reset_ni = 1'b0;
      repeat (2) @(posedge clk_i);
      #1;
      reset_ni = 1'b1;
      hold(AN_2, SEG_2, 10);
      hold(AN_3, SEG_1, 10);
      hold(AN_NONE, SEG_OFF, 10);
      check_eq("mid_rst_data",  32'(data_o), 32'h1200);
      check_eq("mid_rst_valid", 32'(valid_o), 32'h0);
      check_eq("mid_rst_frame", 32'(frame_cnt - frame_base), 32'd0);

      // Clear coinciding with accept of the final digit
      clear_i = 1'b1;
      @(posedge clk_i);
      #1;
      clear_i = 1'b0;
      frame_base = frame_cnt;
      hold(AN_0, SEG_4, 10);
      hold(AN_1, SEG_3, 10);
      hold(AN_2, SEG_2, 10);
      check_eq("pre_clr_data", 32'(data_o), 32'h0234);
      anodes_i = AN_3;
      segs_i   = SEG_1;
      repeat (6) @(posedge clk_i);
      #1;
      clear_i = 1'b1;
      @(posedge clk_i);
      #1;
      clear_i = 1'b0;
      hold(AN_NONE, SEG_OFF, 10);
      check_eq("cc_frame", 32'(frame_cnt - frame_base), 32'd0);
      check_eq("cc_data",  32'(data_o),  32'h0000);
      check_eq("cc_valid", 32'(valid_o), 32'h0);
      check_eq("cc_err",   32'(err_o),   32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
